axi4lite_mem_master: RTL
========================

# axi4lite_mem_master

Parametrised AXI4-Lite master that executes one load or store per request on behalf of the core FSM. Successor to the fixed 32-bit core memory interface, adding configurable data width (32/64), byte/half/word/double sizing with strobe generation, load sign-extension, misalignment trapping, bus-response error reporting and a response timeout. Sits between the core control FSM / register file and the external AXI4-Lite fabric.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, bus and register width; legal values are 32 and 64 only.
- PROT, 3'b000, constant value driven on ARprot/AWprot.
- TIMEOUT, 0, maximum cycles spent waiting in a response state; 0 disables the timeout.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low, named clk and rstn as in the rest of the core.
- clk, in, 1, clock.
- rstn, in, 1, asynchronous active-low reset.
- en, in, 1, request strobe; sampled only when busy=0.
- W_R, in, 1, 1 = store, 0 = load.
- wordsize, in, 2, size: 00 byte, 01 half, 10 word, 11 double (legal only when DATA_W=64).
- signo, in, 1, 1 = sign-extend load result, 0 = zero-extend.
- addr, in, ADDR_W, byte address.
- wdata, in, DATA_W, store data, LSB-justified.
- rdata, out, DATA_W, extended load result; valid while done=1.
- busy, out, 1, transaction in progress.
- done, out, 1, one-cycle completion pulse.
- err, out, 2, completion status, valid with done: 00 ok, 01 misaligned/illegal size, 10 bus error (resp[1]=1), 11 timeout.
- AWaddr/ARaddr, out, ADDR_W, bus addresses, full byte address.
- AWvalid, AWready, Wvalid, Wready, Bvalid, Bready, ARvalid, ARready, Rvalid, RReady: AXI4-Lite handshakes, width 1, directions per AXI (valid/ready as master).
- Wdata, out, DATA_W; Wstrb, out, DATA_W/8; Bresp, in, 2; Rdata, in, DATA_W; Rresp, in, 2.
- AWprot/ARprot, out, 3, tied to PROT.

## Operation
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, FIN.
- IDLE: busy=0. When en=1:
  - If misaligned (addr not a multiple of the size) or illegal size: go to FIN, err=01, no bus activity.
  - Else if W_R=1: go to WADDR. Else: go to RADDR.
  - Request fields are latched in IDLE; input changes later have no effect.
- WADDR: AWvalid and Wvalid assert together; each drops independently after its own handshake. Once both have been accepted (any order, or the same cycle), go to WRESP.
- WRESP: Bready=1. On Bvalid, go to FIN; err=10 if Bresp[1]=1, else 00.
- RADDR: ARvalid=1. On ARready, go to RDATA.
- RDATA: RReady=1. On Rvalid, go to FIN:
  - Rresp[1]=1: err=10 and rdata=0.
  - Otherwise, rdata = the lane selected by addr low bits, shifted down and sign/zero-extended per signo.
- FIN: done=1 and busy=1 for exactly one cycle, then IDLE.
- Write lane mapping:
  - lane = addr[log2(DATA_W/8)-1:0].
  - Wdata = wdata shifted left by lane*8.
  - Wstrb = size mask (1, 3, F, FF) shifted left by lane.
- Timeout: applies only in WRESP and RDATA, where ready may legally be dropped.
  - A counter is cleared on state entry and increments each cycle.
  - When it reaches TIMEOUT without a handshake, go to FIN with err=11 and rdata=0.
  - WADDR and RADDR never abort: AXI forbids retracting valid.

## Timing
- Reset values: all valid/ready outputs 0, busy 0, done 0, err 00, rdata 0, Wstrb 0, addresses and Wdata 0; state IDLE.
- en sampled at edge N:
  - Valid asserts in the cycle after edge N.
  - With a zero-wait slave, the address/data handshake completes at edge N+1 and the response handshake at edge N+2.
  - done is high in the cycle after edge N+2, so minimum latency is 3 cycles en-to-done for both loads and stores.
- Misaligned request: done in the cycle after edge N (1 cycle).
- busy rises the cycle after en is sampled and falls after the done cycle. en is ignored while busy=1 or done=1.
- Back-to-back requests: en may be asserted during the done cycle; it is sampled on the following edge, from IDLE.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous); no completion is reported.

## Structure
- Shared core package holds:
  - size encodings (SZ_B, SZ_H, SZ_W, SZ_D);
  - err encodings (ERR_OK, ERR_ALIGN, ERR_BUS, ERR_TMO);
  - the FSM state enum.
- One natural sub-module: mem_lane_align, purely combinational. It performs strobe/Wdata generation and read extraction with extension, and is reused by the fetch path.
- Elaboration-time check rejects DATA_W other than 32 or 64.

## Test plan
- Store word: DATA_W=32, addr=0x1004, wdata=0xDEADBEEF, zero-wait slave -> Wdata=0xDEADBEEF, Wstrb=F, AWaddr=0x1004, done 3 cycles after en, err=00.
- Store byte, lane 3: addr=0x2003, wdata=0xA5 -> Wdata=0xA5000000, Wstrb=8. AWready delayed 4 cycles and Wready immediate -> Wvalid drops after its handshake, AWvalid held until AWready; done follows B.
- Load half, signed: addr=0x12, Rdata=0x80010000.
  - signo=1 -> rdata=0xFFFF8001.
  - signo=0 -> rdata=0x00008001.
- Misaligned load: wordsize=10, addr=0x6 -> done next cycle, err=01, ARvalid never asserts. Also wordsize=11 with DATA_W=32 -> err=01.
- Bus error and timeout:
  - Rresp=2'b10 -> err=10, rdata=0.
  - TIMEOUT=8 with Bvalid never asserted -> done after 8 WRESP cycles, err=11, Bready deasserted.
- rstn pulled low during RDATA -> RReady=0 and busy=0 immediately, no done pulse. A new load after reset completes normally.

Source files
------------

// File: rtl/axi4lite_mem_master_pkg.sv
// Shared definitions for the core memory master and its lane aligner.
// Holds:
//   - the access size encodings,
//   - the completion status encodings,
//   - the master FSM state type,
//   - an alignment helper used when a request is accepted.
package axi4lite_mem_master_pkg;

    // Access sizes as presented on the wordsize request field
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // Completion status reported alongside done
    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS   = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        FIN
    } state_t;

    // True when the low address bits are not a multiple of the access size
    function automatic logic is_misaligned(input logic [2:0] low, input logic [1:0] size);
        logic r;
        case (size)
            SZ_B:    r = 1'b0;
            SZ_H:    r = low[0];
            SZ_W:    r = |low[1:0];
            default: r = |low;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/axi4lite_mem_master_mem_lane_align.sv
// mem_lane_align: purely combinational byte-lane steering.
// The same block serves the load/store path and the fetch path.
//
// Ports:
//   size      - access size (SZ_B/SZ_H/SZ_W/SZ_D)
//   lane      - byte offset of the access within the bus word
//   signo     - 1 = sign-extend the extracted load value
//   wdata     - LSB-justified store data
//   bus_rdata - raw bus read word
//   bus_wdata - store data moved up to its byte lane
//   bus_wstrb - byte strobes for the store
//   rdata     - load value shifted down and extended to DATA_W
module mem_lane_align #(
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int LANE_W = $clog2(STRB_W)
) (
    input  logic [1:0]        size,
    input  logic [LANE_W-1:0] lane,
    input  logic              signo,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [STRB_W-1:0] bus_wstrb,
    output logic [DATA_W-1:0] rdata
);
    import axi4lite_mem_master_pkg::*;

    logic [LANE_W+2:0] bit_off;
    logic [7:0]        size_mask;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic [6:0]        nbits;
    logic              sign;

    assign bit_off = {lane, 3'b000};

    always_comb begin
        case (size)
            SZ_B:    size_mask = 8'h01;
            SZ_H:    size_mask = 8'h03;
            SZ_W:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign bus_wstrb = size_mask[STRB_W-1:0] << lane;
    assign bus_wdata = wdata << bit_off;

    // The keep mask is built by shifting ones left by the access width.
    // A full-width access shifts everything out, so keep becomes all ones
    // and no extension bits are added.
    always_comb begin
        shifted = bus_rdata >> bit_off;
        case (size)
            SZ_B: begin
                nbits = 7'd8;
                sign  = shifted[7];
            end
            SZ_H: begin
                nbits = 7'd16;
                sign  = shifted[15];
            end
            SZ_W: begin
                nbits = 7'd32;
                sign  = shifted[31];
            end
            default: begin
                nbits = 7'(DATA_W);
                sign  = shifted[DATA_W-1];
            end
        endcase
        keep  = ~({DATA_W{1'b1}} << nbits);
        rdata = (shifted & keep) | ((signo & sign) ? ~keep : '0);
    end

endmodule

// File: rtl/axi4lite_mem_master.sv
// axi4lite_mem_master: AXI4-Lite master executing one load or store per
// request from the core control FSM.
//
// Ports:
//   clk, rstn          - clock, asynchronous active-low reset
//   en, W_R, wordsize  - request strobe, 1=store/0=load, access size
//   signo, addr, wdata - load extension select, byte address, store data
//   rdata              - extended load result, valid while done=1
//   busy, done, err    - in-progress flag, completion pulse, status
//   AW*/W*/B*          - AXI4-Lite write address/data/response channels
//   AR*/R*             - AXI4-Lite read address/data channels
module axi4lite_mem_master #(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter logic [2:0]  PROT    = 3'b000,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  W_R,
    input  logic [1:0]            wordsize,
    input  logic                  signo,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err,
    output logic [ADDR_W-1:0]     AWaddr,
    output logic                  AWvalid,
    input  logic                  AWready,
    output logic [2:0]            AWprot,
    output logic [DATA_W-1:0]     Wdata,
    output logic [DATA_W/8-1:0]   Wstrb,
    output logic                  Wvalid,
    input  logic                  Wready,
    input  logic [1:0]            Bresp,
    input  logic                  Bvalid,
    output logic                  Bready,
    output logic [ADDR_W-1:0]     ARaddr,
    output logic                  ARvalid,
    input  logic                  ARready,
    output logic [2:0]            ARprot,
    input  logic [DATA_W-1:0]     Rdata,
    input  logic [1:0]            Rresp,
    input  logic                  Rvalid,
    output logic                  RReady
);
    import axi4lite_mem_master_pkg::*;

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);

    if (DATA_W != 32 && DATA_W != 64) begin : g_width_check
        $error("axi4lite_mem_master: DATA_W must be 32 or 64");
    end

    state_t              state, state_next;
    logic [1:0]          size_q;
    logic                signo_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          err_q;
    logic                aw_done, w_done;
    logic [31:0]         tmo_cnt;

    logic                misaligned;
    logic                aw_ok, w_ok;
    logic                tmo_hit;
    logic                fin_load;
    logic [1:0]          fin_err;
    logic [DATA_W-1:0]   fin_rdata;

    logic [DATA_W-1:0]   lane_wdata;
    logic [STRB_W-1:0]   lane_wstrb;
    logic [DATA_W-1:0]   lane_rdata;

    // Only resp[1] distinguishes error responses; EXOKAY is not used
    logic                unused_resp;
    assign unused_resp = Bresp[0] ^ Rresp[0];

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .size      (size_q),
        .lane      (addr_q[LANE_W-1:0]),
        .signo     (signo_q),
        .wdata     (wdata_q),
        .bus_rdata (Rdata),
        .bus_wdata (lane_wdata),
        .bus_wstrb (lane_wstrb),
        .rdata     (lane_rdata)
    );

    // A double access on a 32-bit bus can never be carried out
    assign misaligned = is_misaligned(addr[2:0], wordsize) ||
                        ((wordsize == SZ_D) && (DATA_W == 32));

    // AW and W may complete in either order; each side is remembered
    assign aw_ok = aw_done | AWready;
    assign w_ok  = w_done  | Wready;

    // The counter holds the number of response cycles already spent, so the
    // abort fires at the end of the TIMEOUT-th waiting cycle
    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TIMEOUT - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fin_load   = 1'b0;
        fin_err    = ERR_OK;
        fin_rdata  = '0;
        case (state)
            IDLE: begin
                if (en) begin
                    if (misaligned) begin
                        state_next = FIN;
                        fin_load   = 1'b1;
                        fin_err    = ERR_ALIGN;
                    end else if (W_R) begin
                        state_next = WADDR;
                    end else begin
                        state_next = RADDR;
                    end
                end
            end
            WADDR: begin
                if (aw_ok && w_ok) begin
                    state_next = WRESP;
                end
            end
            WRESP: begin
                if (Bvalid) begin
                    state_next = FIN;
                    fin_load   = 1'b1;
                    fin_err    = Bresp[1] ? ERR_BUS : ERR_OK;
                end else if (tmo_hit) begin
                    state_next = FIN;
                    fin_load   = 1'b1;
                    fin_err    = ERR_TMO;
                end
            end
            RADDR: begin
                if (ARready) begin
                    state_next = RDATA;
                end
            end
            RDATA: begin
                if (Rvalid) begin
                    state_next = FIN;
                    fin_load   = 1'b1;
                    if (Rresp[1]) begin
                        fin_err = ERR_BUS;
                    end else begin
                        fin_rdata = lane_rdata;
                    end
                end else if (tmo_hit) begin
                    state_next = FIN;
                    fin_load   = 1'b1;
                    fin_err    = ERR_TMO;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture and completion status. Status and result are cleared
    // when a request is accepted so stores and aborts report rdata=0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            size_q  <= SZ_B;
            signo_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            if (state == IDLE && en) begin
                size_q  <= wordsize;
                signo_q <= signo;
                addr_q  <= addr;
                wdata_q <= wdata;
                rdata_q <= '0;
                err_q   <= ERR_OK;
            end
            if (fin_load) begin
                rdata_q <= fin_rdata;
                err_q   <= fin_err;
            end
        end
    end

    // Per-channel acceptance flags for the write address/data phase
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == WADDR) begin
            if (AWvalid && AWready) aw_done <= 1'b1;
            if (Wvalid && Wready)   w_done  <= 1'b1;
        end else begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end
    end

    // Response wait counter, restarted on every state change
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt <= '0;
        end else if (state_next != state) begin
            tmo_cnt <= '0;
        end else if (state == WRESP || state == RDATA) begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == FIN);
    assign err     = err_q;
    assign rdata   = rdata_q;

    assign AWaddr  = addr_q;
    assign ARaddr  = addr_q;
    assign AWprot  = PROT;
    assign ARprot  = PROT;
    assign AWvalid = (state == WADDR) && !aw_done;
    assign Wvalid  = (state == WADDR) && !w_done;
    assign Wdata   = (state == WADDR) ? lane_wdata : '0;
    assign Wstrb   = (state == WADDR) ? lane_wstrb : '0;
    assign Bready  = (state == WRESP);
    assign ARvalid = (state == RADDR);
    assign RReady  = (state == RDATA);

endmodule
